// File: rtl/konami_pkg.sv
// Shared constants for the Konami-code acceptor display: segment glyphs
// (bit 0 = segment A, bit 6 = segment G) and the acceptor state encoding.
package konami_pkg;

    localparam logic [6:0] GLYPH_U     = 7'b0111110;
    localparam logic [6:0] GLYPH_P     = 7'b1110011;
    localparam logic [6:0] GLYPH_D     = 7'b1011110;
    localparam logic [6:0] GLYPH_N     = 7'b1010100;
    localparam logic [6:0] GLYPH_L     = 7'b0111000;
    localparam logic [6:0] GLYPH_F     = 7'b1110001;
    localparam logic [6:0] GLYPH_R     = 7'b1010000;
    localparam logic [6:0] GLYPH_H     = 7'b1110100;
    localparam logic [6:0] GLYPH_ZERO  = 7'b0111111;
    localparam logic [6:0] GLYPH_ONE   = 7'b0000110;
    localparam logic [6:0] GLYPH_TWO   = 7'b1011011;
    localparam logic [6:0] GLYPH_NINE  = 7'b1101111;
    localparam logic [6:0] GLYPH_DASH  = 7'b1000000;
    localparam logic [6:0] GLYPH_BLANK = 7'b0000000;

    typedef enum logic [3:0] {
        ST_IDLE   = 4'd0,
        ST_STEP1  = 4'd1,
        ST_STEP2  = 4'd2,
        ST_STEP3  = 4'd3,
        ST_STEP4  = 4'd4,
        ST_STEP5  = 4'd5,
        ST_STEP6  = 4'd6,
        ST_STEP7  = 4'd7,
        ST_STEP8  = 4'd8,
        ST_ACCEPT = 4'd9,
        ST_ERR1   = 4'd10,
        ST_ERR2   = 4'd11,
        ST_ERR3   = 4'd12,
        ST_ERR4   = 4'd13,
        ST_ERR5   = 4'd14,
        ST_ERR6   = 4'd15
    } acceptor_state_e;

    localparam logic [3:0] ACCEPT_STATE = ST_ACCEPT;

endpackage

// File: rtl/konami_glyph_rom.sv
// Combinational glyph lookup: segment pattern for one digit position of a
// given acceptor state. Positions 4 and up are always blank.
module konami_glyph_rom
    import konami_pkg::*;
(
    input  logic [3:0] state,
    input  logic [2:0] digit,
    output logic [6:0] seg
);

    logic [6:0] col0;
    logic [6:0] col1;
    logic [6:0] col3;

    always_comb begin
        col0 = GLYPH_DASH;
        col1 = GLYPH_DASH;
        col3 = GLYPH_DASH;

        // Steps pair up as direction words (up/dn/lf/rh) plus a 1/2 ordinal.
        case (acceptor_state_e'(state))
            ST_STEP1, ST_STEP2: begin col0 = GLYPH_U; col1 = GLYPH_P; end
            ST_STEP3, ST_STEP4: begin col0 = GLYPH_D; col1 = GLYPH_N; end
            ST_STEP5, ST_STEP7: begin col0 = GLYPH_L; col1 = GLYPH_F; end
            ST_STEP6, ST_STEP8: begin col0 = GLYPH_R; col1 = GLYPH_H; end
            default: ;
        endcase

        case (acceptor_state_e'(state))
            ST_STEP1, ST_STEP3, ST_STEP5, ST_STEP6: col3 = GLYPH_ONE;
            ST_STEP2, ST_STEP4, ST_STEP7, ST_STEP8: col3 = GLYPH_TWO;
            default: ;
        endcase

        seg = GLYPH_BLANK;
        if (!digit[2]) begin
            if (state == ACCEPT_STATE) begin
                seg = GLYPH_NINE;
            end else if (state > ACCEPT_STATE) begin
                seg = GLYPH_ZERO;
            end else begin
                case (digit[1:0])
                    2'd0:    seg = col0;
                    2'd1:    seg = col1;
                    2'd2:    seg = GLYPH_DASH;
                    default: seg = col3;
                endcase
            end
        end
    end

endmodule

// File: rtl/konami_scan_display.sv
// Multiplexed 7-segment scanner showing the acceptor state, with blinking
// in the accept state. Outputs are registered (one cycle behind the scan).
module konami_scan_display
    import konami_pkg::*;
#(
    parameter int NUM_DIGITS = 4,
    parameter int SCAN_DIV   = 1000,
    parameter int BLINK_DIV  = 64
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic [3:0]            state,
    input  logic                  enable,
    output logic [6:0]            seg,
    output logic [NUM_DIGITS-1:0] digit_sel
);

    localparam int P_W = (SCAN_DIV > 1) ? $clog2(SCAN_DIV) : 1;
    localparam int F_W = (BLINK_DIV > 1) ? $clog2(BLINK_DIV) : 1;
    localparam logic [P_W-1:0] P_LAST = P_W'(SCAN_DIV - 1);
    localparam logic [F_W-1:0] F_LAST = F_W'(BLINK_DIV - 1);
    localparam logic [2:0]     D_LAST = 3'(NUM_DIGITS - 1);

    logic [P_W-1:0]        p_q, p_d;
    logic [2:0]            d_q, d_d;
    logic [3:0]            latched_state_q, latched_state_d;
    logic [F_W-1:0]        frame_q, frame_d;
    logic                  blink_on_q, blink_on_d;
    logic [6:0]            seg_q, seg_d;
    logic [NUM_DIGITS-1:0] digit_sel_q, digit_sel_d;

    logic [6:0] glyph;
    logic       p_tc;
    logic       frame_end;

    konami_glyph_rom u_glyph_rom (
        .state (latched_state_q),
        .digit (d_q),
        .seg   (glyph)
    );

    always_comb begin
        p_tc      = (p_q == P_LAST);
        frame_end = p_tc && (d_q == D_LAST);

        p_d = p_tc ? '0 : p_q + P_W'(1);
        d_d = d_q;
        if (p_tc) begin
            d_d = (d_q == D_LAST) ? '0 : d_q + 3'd1;
        end

        latched_state_d = frame_end ? state : latched_state_q;

        // Keyed on the incoming latched state so the first frame after
        // leaving accept is already visible; counting only covers frames
        // that were themselves shown as accept.
        frame_d    = frame_q;
        blink_on_d = blink_on_q;
        if (latched_state_d != ACCEPT_STATE) begin
            frame_d    = '0;
            blink_on_d = 1'b1;
        end else if (frame_end && (latched_state_q == ACCEPT_STATE)) begin
            if (frame_q == F_LAST) begin
                frame_d    = '0;
                blink_on_d = ~blink_on_q;
            end else begin
                frame_d = frame_q + F_W'(1);
            end
        end

        seg_d       = GLYPH_BLANK;
        digit_sel_d = '0;
        if (enable && blink_on_q) begin
            seg_d       = glyph;
            digit_sel_d = NUM_DIGITS'(1) << d_q;
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            p_q             <= '0;
            d_q             <= '0;
            latched_state_q <= ST_IDLE;
            frame_q         <= '0;
            blink_on_q      <= 1'b1;
            seg_q           <= '0;
            digit_sel_q     <= '0;
        end else begin
            p_q             <= p_d;
            d_q             <= d_d;
            latched_state_q <= latched_state_d;
            frame_q         <= frame_d;
            blink_on_q      <= blink_on_d;
            seg_q           <= seg_d;
            digit_sel_q     <= digit_sel_d;
        end
    end

    assign seg       = seg_q;
    assign digit_sel = digit_sel_q;

endmodule

// File: tb/tb_konami_scan_display.sv
// Self-checking bench: two display instances (4-digit slow scan, 6-digit
// single-cycle scan) checked against a frame/arithmetic reference model.
module tb_konami_scan_display;

    localparam int ND_A = 4, SD_A = 4, BD_A = 2;
    localparam int ND_B = 6, SD_B = 1, BD_B = 3;

    localparam logic [6:0] G_U    = 7'b0111110;
    localparam logic [6:0] G_P    = 7'b1110011;
    localparam logic [6:0] G_D    = 7'b1011110;
    localparam logic [6:0] G_N    = 7'b1010100;
    localparam logic [6:0] G_L    = 7'b0111000;
    localparam logic [6:0] G_F    = 7'b1110001;
    localparam logic [6:0] G_R    = 7'b1010000;
    localparam logic [6:0] G_H    = 7'b1110100;
    localparam logic [6:0] G_ZERO = 7'b0111111;
    localparam logic [6:0] G_ONE  = 7'b0000110;
    localparam logic [6:0] G_TWO  = 7'b1011011;
    localparam logic [6:0] G_NINE = 7'b1101111;
    localparam logic [6:0] G_DASH = 7'b1000000;

    logic            clk    = 1'b0;
    logic            reset  = 1'b1;
    logic            enable = 1'b0;
    logic [3:0]      state  = 4'd0;
    logic [6:0]      a_seg, b_seg;
    logic [ND_A-1:0] a_sel;
    logic [ND_B-1:0] b_sel;

    int n_checks = 0;
    int n_fail   = 0;
    bit chk_en   = 1'b0;

    konami_scan_display #(.NUM_DIGITS(ND_A), .SCAN_DIV(SD_A), .BLINK_DIV(BD_A)) dut_a (
        .clk(clk), .reset(reset), .state(state), .enable(enable),
        .seg(a_seg), .digit_sel(a_sel)
    );

    konami_scan_display #(.NUM_DIGITS(ND_B), .SCAN_DIV(SD_B), .BLINK_DIV(BD_B)) dut_b (
        .clk(clk), .reset(reset), .state(state), .enable(enable),
        .seg(b_seg), .digit_sel(b_sel)
    );

    always #5 clk = ~clk;

    function automatic logic [6:0] ref_glyph(input int s, input int dg);
        logic [27:0] row; // {digit3, digit2, digit1, digit0}
        case (s)
            0:       row = {4{G_DASH}};
            1:       row = {G_ONE, G_DASH, G_P, G_U};
            2:       row = {G_TWO, G_DASH, G_P, G_U};
            3:       row = {G_ONE, G_DASH, G_N, G_D};
            4:       row = {G_TWO, G_DASH, G_N, G_D};
            5:       row = {G_ONE, G_DASH, G_F, G_L};
            6:       row = {G_ONE, G_DASH, G_H, G_R};
            7:       row = {G_TWO, G_DASH, G_F, G_L};
            8:       row = {G_TWO, G_DASH, G_H, G_R};
            9:       row = {4{G_NINE}};
            default: row = {4{G_ZERO}};
        endcase
        if (dg >= 4) return 7'b0;
        return row[dg*7 +: 7];
    endfunction

    task automatic check(input string nm, input logic [7:0] got, input logic [7:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %b expected %b at %0t", nm, got, exp, $time);
        end
    endtask

    // Reference model: edge count since reset gives scan position; each
    // frame's state is sampled on its starting edge; blink phase follows from
    // how many consecutive accept frames preceded.
    int         m_n[2], m_lat[2], m_run[2];
    logic [7:0] e_seg[2], e_sel[2];
    int         m_nd, m_sd, m_bd, m_dg;
    bit         m_vis;

    initial begin
        for (int i = 0; i < 2; i++) begin
            m_n[i] = 0; m_lat[i] = 0; m_run[i] = 0; e_seg[i] = '0; e_sel[i] = '0;
        end
        forever begin
            @(posedge clk or posedge reset);
            for (int i = 0; i < 2; i++) begin
                if (reset) begin
                    m_n[i] = 0; m_lat[i] = 0; m_run[i] = 0; e_seg[i] = '0; e_sel[i] = '0;
                end else begin
                    m_nd = (i == 0) ? ND_A : ND_B;
                    m_sd = (i == 0) ? SD_A : SD_B;
                    m_bd = (i == 0) ? BD_A : BD_B;
                    m_n[i]++;
                    m_dg  = ((m_n[i] - 1) / m_sd) % m_nd;
                    m_vis = enable && (((m_run[i] / m_bd) % 2) == 0);
                    e_sel[i] = m_vis ? 8'(1 << m_dg) : 8'h00;
                    e_seg[i] = m_vis ? 8'(ref_glyph(m_lat[i], m_dg)) : 8'h00;
                    if ((m_n[i] % (m_sd * m_nd)) == 0) begin
                        m_run[i] = (state == 4'd9 && m_lat[i] == 9) ? m_run[i] + 1 : 0;
                        m_lat[i] = int'(state);
                    end
                end
            end
        end
    end

    initial begin
        forever begin
            @(negedge clk);
            if (chk_en) begin
                check("model_a_seg", 8'(a_seg), e_seg[0]);
                check("model_a_sel", 8'(a_sel), e_sel[0]);
                check("model_b_seg", 8'(b_seg), e_seg[1]);
                check("model_b_sel", 8'(b_sel), e_sel[1]);
            end
        end
    end

    task automatic wait_for(input bit use_b, input logic [7:0] sel_t, input bit chk_seg,
                            input logic [6:0] seg_t, input string nm);
        bit hit = 1'b0;
        for (int k = 0; k < 400 && !hit; k++) begin
            @(negedge clk);
            if (use_b) hit = (8'(b_sel) == sel_t) && (!chk_seg || b_seg == seg_t);
            else       hit = (8'(a_sel) == sel_t) && (!chk_seg || a_seg == seg_t);
        end
        if (!hit) begin
            n_checks++;
            n_fail++;
            $display("FAIL %s: timeout, digit_sel never reached %b", nm, sel_t);
        end
    endtask

    typedef struct {
        logic [3:0] st;
        int         dg;
        logic [6:0] seg;
    } vec_t;

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached");
        n_fail++;
        $fatal(1, "End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    end

    initial begin
        vec_t vecs[21];
        int   vis_cnt;
        int   exp_cnt[5];
        bit   all_zero;

        vecs[0]  = '{st: 4'd0,  dg: 0, seg: G_DASH};
        vecs[1]  = '{st: 4'd0,  dg: 3, seg: G_DASH};
        vecs[2]  = '{st: 4'd1,  dg: 0, seg: G_U};
        vecs[3]  = '{st: 4'd1,  dg: 3, seg: G_ONE};
        vecs[4]  = '{st: 4'd2,  dg: 1, seg: G_P};
        vecs[5]  = '{st: 4'd2,  dg: 3, seg: G_TWO};
        vecs[6]  = '{st: 4'd3,  dg: 0, seg: G_D};
        vecs[7]  = '{st: 4'd4,  dg: 1, seg: G_N};
        vecs[8]  = '{st: 4'd4,  dg: 3, seg: G_TWO};
        vecs[9]  = '{st: 4'd5,  dg: 0, seg: G_L};
        vecs[10] = '{st: 4'd5,  dg: 3, seg: G_ONE};
        vecs[11] = '{st: 4'd6,  dg: 0, seg: 7'b1010000};
        vecs[12] = '{st: 4'd6,  dg: 1, seg: 7'b1110100};
        vecs[13] = '{st: 4'd6,  dg: 2, seg: 7'b1000000};
        vecs[14] = '{st: 4'd6,  dg: 3, seg: 7'b0000110};
        vecs[15] = '{st: 4'd7,  dg: 1, seg: G_F};
        vecs[16] = '{st: 4'd7,  dg: 3, seg: G_TWO};
        vecs[17] = '{st: 4'd8,  dg: 0, seg: G_R};
        vecs[18] = '{st: 4'd8,  dg: 3, seg: G_TWO};
        vecs[19] = '{st: 4'd10, dg: 2, seg: G_ZERO};
        vecs[20] = '{st: 4'd15, dg: 0, seg: G_ZERO};

        // Reset state
        enable = 1'b1;
        state  = 4'd0;
        repeat (3) @(negedge clk);
        check("reset_a_seg", 8'(a_seg), 8'h00);
        check("reset_a_sel", 8'(a_sel), 8'h00);
        check("reset_b_sel", 8'(b_sel), 8'h00);
        reset  = 1'b0;
        chk_en = 1'b1;
        @(negedge clk);
        check("first_a_sel", 8'(a_sel), 8'b0001);
        check("first_a_seg", 8'(a_seg), 8'(G_DASH));
        check("first_b_sel", 8'(b_sel), 8'b000001);

        // Idle scan: each digit strobed for SCAN_DIV cycles, dash throughout
        for (int c = 0; c < 16; c++) begin
            if (c > 0) @(negedge clk);
            check("idle_scan_sel", 8'(a_sel), 8'(1 << ((c / 4) % 4)));
            check("idle_scan_seg", 8'(a_seg), 8'(G_DASH));
        end

        // Glyph table
        for (int v = 0; v < 21; v++) begin
            state = vecs[v].st;
            repeat (32) @(negedge clk);
            wait_for(1'b0, 8'(1 << vecs[v].dg), 1'b0, 7'b0, "glyph_wait");
            check($sformatf("glyph_s%0d_d%0d", vecs[v].st, vecs[v].dg), 8'(a_seg), 8'(vecs[v].seg));
        end

        // State change mid-frame: rest of the frame keeps the old glyphs
        state = 4'd3;
        repeat (32) @(negedge clk);
        wait_for(1'b0, 8'b0100, 1'b0, 7'b0, "midframe_wait_d2");
        state = 4'd4;
        check("midframe_d2", 8'(a_seg), 8'(G_DASH));
        wait_for(1'b0, 8'b1000, 1'b0, 7'b0, "midframe_wait_d3");
        check("midframe_d3_old", 8'(a_seg), 8'(G_ONE));
        wait_for(1'b0, 8'b0001, 1'b0, 7'b0, "midframe_wait_d0");
        check("midframe_d0_new", 8'(a_seg), 8'(G_D));
        wait_for(1'b0, 8'b1000, 1'b0, 7'b0, "midframe_wait_d3b");
        check("midframe_d3_new", 8'(a_seg), 8'(G_TWO));

        // Blink: 2 visible frames, 2 dark, leaving accept restores next frame
        exp_cnt = '{16, 16, 0, 0, 16};
        state = 4'd9;
        wait_for(1'b0, 8'b0001, 1'b1, G_NINE, "blink_wait_start");
        for (int f = 0; f < 5; f++) begin
            if (f == 3) state = 4'd0;
            if (f == 4) check("blink_restore_seg", 8'(a_seg), 8'(G_DASH));
            vis_cnt = 0;
            for (int c = 0; c < 16; c++) begin
                if (a_sel != '0) vis_cnt++;
                @(negedge clk);
            end
            check($sformatf("blink_frame%0d_visible", f), 8'(vis_cnt), 8'(exp_cnt[f]));
        end

        // Six digits: upper positions strobe blank; enable low keeps timing
        state = 4'd1;
        repeat (20) @(negedge clk);
        wait_for(1'b1, 8'b010000, 1'b0, 7'b0, "six_wait_d4");
        check("six_d4_blank", 8'(b_seg), 8'h00);
        wait_for(1'b1, 8'b100000, 1'b0, 7'b0, "six_wait_d5");
        check("six_d5_blank", 8'(b_seg), 8'h00);
        wait_for(1'b1, 8'b000001, 1'b0, 7'b0, "six_wait_d0");
        enable   = 1'b0;
        all_zero = 1'b1;
        for (int c = 0; c < 12; c++) begin
            @(negedge clk);
            if (b_sel != '0 || b_seg != '0) all_zero = 1'b0;
        end
        check("enable_off_dark", 8'(all_zero), 8'h01);
        enable = 1'b1;
        @(negedge clk);
        check("enable_on_timing", 8'(b_sel), 8'b000010);

        // Asynchronous reset between clock edges
        @(posedge clk);
        #2 reset = 1'b1;
        #1;
        check("async_rst_a_sel", 8'(a_sel), 8'h00);
        check("async_rst_a_seg", 8'(a_seg), 8'h00);
        check("async_rst_b_sel", 8'(b_sel), 8'h00);
        @(negedge clk);
        reset = 1'b0;
        @(negedge clk);
        check("post_rst_a_sel", 8'(a_sel), 8'b0001);
        check("post_rst_a_seg", 8'(a_seg), 8'(G_DASH));

        // Random traffic against the model, biased toward the accept state
        for (int c = 0; c < 1500; c++) begin
            @(negedge clk);
            if ($urandom_range(0, 9) == 0)
                state = ($urandom_range(0, 2) == 0) ? 4'd9 : 4'($urandom_range(0, 15));
            if ($urandom_range(0, 29) == 0) enable = ~enable;
            if (c == 700) begin
                reset = 1'b1;
                @(negedge clk);
                reset = 1'b0;
            end
        end

        chk_en = 1'b0;
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
